// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller:
// opcodes, FSM state codes and datapath mux select codes.
package cpu_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  typedef enum logic [3:0] {
    StIf    = 4'd0,
    StId    = 4'd1,
    StMaddr = 4'd2,
    StMrd   = 4'd3,
    StMwb   = 4'd4,
    StMwr   = 4'd5,
    StRex   = 4'd6,
    StRwb   = 4'd7,
    StBeq   = 4'd8,
    StJmp   = 4'd9,
    StIex   = 4'd10,
    StIwb   = 4'd11
  } state_e;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Control bus between the multi-cycle controller (master) and the datapath (slave).
interface multi_cycle_ctrl_if;
  logic [5:0] OPCode;
  logic       MemReady;
  logic       ZF;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       PCEn;
  logic       IorD;
  logic       MemRd;
  logic       MemWr;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWr;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOP;
  logic [1:0] PCSource;

  modport master (
    input  OPCode, MemReady, ZF,
    output PCWrite, PCWriteCond, PCEn, IorD, MemRd, MemWr, IRWrite,
    output MemtoReg, RegDst, RegWr, ALUSrcA, ALUSrcB, ALUOP, PCSource
  );

  modport slave (
    output OPCode, MemReady, ZF,
    input  PCWrite, PCWriteCond, PCEn, IorD, MemRd, MemWr, IRWrite,
    input  MemtoReg, RegDst, RegWr, ALUSrcA, ALUSrcB, ALUOP, PCSource
  );
endinterface

// File: rtl/ctrl_op_decode.sv
// Opcode decode for the ID state: selects the next state and flags undefined opcodes.
module ctrl_op_decode
  import cpu_pkg::*;
(
  input  logic [5:0] OPCode,
  output state_e     next_state,
  output logic       illegal
);

  always_comb begin
    next_state = StIf;
    illegal    = 1'b0;
    case (OPCode)
      OpLw, OpSw: next_state = StMaddr;
      OpRtype:    next_state = StRex;
      OpBeq:      next_state = StBeq;
      OpJ:        next_state = StJmp;
      OpAddi:     next_state = StIex;
      default:    illegal    = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Moore main controller for the multi-cycle MIPS-subset datapath; IRWrite/PCWrite in IF
// additionally depend on MemReady. Tracks retired instructions and a sticky illegal flag.
module multi_cycle_ctrl
  import cpu_pkg::*;
(
  input  logic                CLK,
  input  logic                nRST,
  multi_cycle_ctrl_if.master  ctrl,
  output logic [3:0]          State,
  output logic                Illegal,
  output logic [31:0]         RetireCnt
);

  state_e      state_q, state_d, id_next;
  logic        run_q, store_q, illegal_q, id_illegal, retire, active;
  logic [31:0] retire_cnt_q;

  logic       pc_write, pc_write_cond, ior_d, mem_rd, mem_wr, ir_write;
  logic       mem_to_reg, reg_dst, reg_wr, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;

  ctrl_op_decode u_op_decode (
    .OPCode     (ctrl.OPCode),
    .next_state (id_next),
    .illegal    (id_illegal)
  );

  // run_q holds the machine idle until the first edge after reset release.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= StIf;
      run_q        <= 1'b0;
      store_q      <= 1'b0;
      illegal_q    <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      if (state_q == StId) begin
        store_q <= (ctrl.OPCode == OpSw);
        if (id_illegal) illegal_q <= 1'b1;
      end
      if (retire) retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      StIf:    if (run_q && ctrl.MemReady) state_d = StId;
      StId:    state_d = id_next;
      StMaddr: state_d = store_q ? StMwr : StMrd;
      StMrd:   if (ctrl.MemReady) state_d = StMwb;
      StMwr: begin
        if (ctrl.MemReady) begin
          state_d = StIf;
          retire  = 1'b1;
        end
      end
      StRex:   state_d = StRwb;
      StIex:   state_d = StIwb;
      StMwb, StRwb, StBeq, StJmp, StIwb: begin
        state_d = StIf;
        retire  = 1'b1;
      end
      default: state_d = StIf;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ior_d         = 1'b0;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_wr        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SrcBReg;
    alu_op        = AluAdd;
    pc_source     = PcSrcAlu;
    unique case (state_q)
      StIf: begin
        mem_rd    = 1'b1;
        alu_src_b = SrcBFour;
        ir_write  = ctrl.MemReady;
        pc_write  = ctrl.MemReady;
      end
      StId:    alu_src_b = SrcBImmSh;
      StMaddr: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
      end
      StMrd: begin
        mem_rd = 1'b1;
        ior_d  = 1'b1;
      end
      StMwb: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMwr: begin
        mem_wr = 1'b1;
        ior_d  = 1'b1;
      end
      StRex: begin
        alu_src_a = 1'b1;
        alu_op    = AluFunct;
      end
      StRwb: begin
        reg_wr  = 1'b1;
        reg_dst = 1'b1;
      end
      StBeq: begin
        alu_src_a     = 1'b1;
        alu_op        = AluSub;
        pc_write_cond = 1'b1;
        pc_source     = PcSrcAluOut;
      end
      StJmp: begin
        pc_write  = 1'b1;
        pc_source = PcSrcJump;
      end
      StIex: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
      end
      StIwb:   reg_wr = 1'b1;
      default: ;
    endcase
  end

  // nRST gates combinationally so strobes drop the instant reset asserts.
  assign active = run_q & nRST;

  assign ctrl.PCWrite     = active & pc_write;
  assign ctrl.PCWriteCond = active & pc_write_cond;
  assign ctrl.PCEn        = active & (pc_write | (pc_write_cond & ctrl.ZF));
  assign ctrl.IorD        = active & ior_d;
  assign ctrl.MemRd       = active & mem_rd;
  assign ctrl.MemWr       = active & mem_wr;
  assign ctrl.IRWrite     = active & ir_write;
  assign ctrl.MemtoReg    = active & mem_to_reg;
  assign ctrl.RegDst      = active & reg_dst;
  assign ctrl.RegWr       = active & reg_wr;
  assign ctrl.ALUSrcA     = active & alu_src_a;
  assign ctrl.ALUSrcB     = active ? alu_src_b : 2'b00;
  assign ctrl.ALUOP       = active ? alu_op    : 2'b00;
  assign ctrl.PCSource    = active ? pc_source : 2'b00;

  assign State     = state_q;
  assign Illegal   = illegal_q;
  assign RetireCnt = retire_cnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized self-checking bench for multi_cycle_ctrl against a phase-list reference model.
module tb_multi_cycle_ctrl;
  import cpu_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [3:0]  State;
  logic        Illegal;
  logic [31:0] RetireCnt;

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .ctrl      (bus.master),
    .State     (State),
    .Illegal   (Illegal),
    .RetireCnt (RetireCnt)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_retire = 32'd0;
  logic        exp_illegal = 1'b0;
  logic [5:0]  legal_ops [6] = '{OpRtype, OpLw, OpSw, OpBeq, OpJ, OpAddi};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [16:0] ctrl_vec();
    return {bus.PCWrite, bus.PCWriteCond, bus.PCEn, bus.IorD, bus.MemRd, bus.MemWr,
            bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWr, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUOP, bus.PCSource};
  endfunction

  // Expected control word for a named phase, straight from the per-state output table.
  function automatic logic [16:0] exp_vec(input string p, input bit rdy, input bit zf);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca;
    logic [1:0] srcb, aop, psrc;
    pcw = 0; pcwc = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; m2r = 0;
    rdst = 0; rwr = 0; srca = 0; srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (p)
      "IF":    begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      "ID":    srcb = 2'b11;
      "MADDR": begin srca = 1; srcb = 2'b10; end
      "MRD":   begin mrd = 1; iord = 1; end
      "MWB":   begin rwr = 1; m2r = 1; end
      "MWR":   begin mwr = 1; iord = 1; end
      "REX":   begin srca = 1; aop = 2'b10; end
      "RWB":   begin rwr = 1; rdst = 1; end
      "BEQ":   begin srca = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      "JMP":   begin pcw = 1; psrc = 2'b10; end
      "IEX":   begin srca = 1; srcb = 2'b10; end
      "IWB":   rwr = 1;
      default: ;
    endcase
    return {pcw, pcwc, pcw | (pcwc & zf), iord, mrd, mwr, irw, m2r, rdst, rwr, srca,
            srcb, aop, psrc};
  endfunction

  function automatic logic [3:0] phase_state(input string p);
    case (p)
      "IF":    return StIf;
      "ID":    return StId;
      "MADDR": return StMaddr;
      "MRD":   return StMrd;
      "MWB":   return StMwb;
      "MWR":   return StMwr;
      "REX":   return StRex;
      "RWB":   return StRwb;
      "BEQ":   return StBeq;
      "JMP":   return StJmp;
      "IEX":   return StIex;
      default: return StIwb;
    endcase
  endfunction

  // One instruction: phases come from the opcode; IF/MRD/MWR repeat while MemReady is low.
  // mrd_stalls >= 0 fixes the MRD stall count; zf_sel >= 0 fixes ZF.
  task automatic run_instr(input logic [5:0] op, input int stall_pct, input int mrd_stalls,
                           input int zf_sel, input bit abort_mwr);
    string ph[$];
    bit    legal;
    ph.push_back("IF");
    ph.push_back("ID");
    case (op)
      OpRtype: begin ph.push_back("REX"); ph.push_back("RWB"); end
      OpLw:    begin ph.push_back("MADDR"); ph.push_back("MRD"); ph.push_back("MWB"); end
      OpSw:    begin ph.push_back("MADDR"); ph.push_back("MWR"); end
      OpBeq:   ph.push_back("BEQ");
      OpJ:     ph.push_back("JMP");
      OpAddi:  begin ph.push_back("IEX"); ph.push_back("IWB"); end
      default: ;
    endcase
    legal = (ph.size() > 2);
    for (int i = 0; i < ph.size(); i++) begin
      string p;
      bit    rdy, zf, stall;
      int    k;
      p = ph[i];
      k = 0;
      do begin
        @(negedge CLK);
        if (p == "MRD" && mrd_stalls >= 0) rdy = (k >= mrd_stalls);
        else rdy = ($urandom_range(99) >= stall_pct);
        zf = (zf_sel < 0) ? 1'($urandom) : zf_sel[0];
        bus.MemReady = rdy;
        bus.ZF       = zf;
        bus.OPCode   = (p == "IF") ? 6'($urandom) : op;
        if (abort_mwr && p == "MWR") begin
          bus.MemReady = 1'b0;
          #1;
          check("abort_memwr_pre", 32'(bus.MemWr), 32'd1);
          nRST = 1'b0;
          #1;
          check("abort_memwr", 32'(bus.MemWr), 32'd0);
          check("abort_state", 32'(State), 32'(StIf));
          check("abort_retire", RetireCnt, 32'd0);
          exp_retire  = 32'd0;
          exp_illegal = 1'b0;
          return;
        end
        #1;
        check($sformatf("%02b_%s_state", op, p), 32'(State), 32'(phase_state(p)));
        check($sformatf("%06b_%s_ctl", op, p), 32'(ctrl_vec()), 32'(exp_vec(p, rdy, zf)));
        check($sformatf("%06b_%s_ret", op, p), RetireCnt, exp_retire);
        check($sformatf("%06b_%s_ill", op, p), 32'(Illegal), 32'(exp_illegal));
        stall = (p == "IF" || p == "MRD" || p == "MWR") && !rdy;
        k++;
      end while (stall);
    end
    if (legal) exp_retire = exp_retire + 32'd1;
    else exp_illegal = 1'b1;
  endtask

  task automatic release_reset();
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check("release_idle_ctl", 32'(ctrl_vec()), 32'd0);
    check("release_idle_state", 32'(State), 32'(StIf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] op;
    nRST         = 1'b0;
    bus.MemReady = 1'b1;
    bus.ZF       = 1'b1;
    bus.OPCode   = OpRtype;
    #12;
    check("reset_ctl", 32'(ctrl_vec()), 32'd0);
    check("reset_state", 32'(State), 32'(StIf));
    check("reset_retire", RetireCnt, 32'd0);
    check("reset_illegal", 32'(Illegal), 32'd0);
    release_reset();

    run_instr(OpRtype, 0, -1, -1, 1'b0);
    run_instr(OpLw, 0, 2, -1, 1'b0);
    run_instr(OpBeq, 0, -1, 1, 1'b0);
    run_instr(OpBeq, 0, -1, 0, 1'b0);
    run_instr(6'b111111, 0, -1, -1, 1'b0);
    run_instr(OpAddi, 0, -1, -1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(5)];
      run_instr(op, 30, -1, -1, 1'b0);
    end

    run_instr(OpSw, 0, -1, -1, 1'b1);
    release_reset();
    run_instr(OpRtype, 20, -1, -1, 1'b0);

    // Preload the counter just below wrap while the machine idles in IF.
    @(negedge CLK);
    bus.MemReady = 1'b0;
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    @(negedge CLK);
    release dut.retire_cnt_q;
    exp_retire = 32'hFFFF_FFFF;
    run_instr(OpJ, 0, -1, -1, 1'b0);
    @(negedge CLK);
    bus.MemReady = 1'b0;
    #1;
    check("wrap_retire", RetireCnt, exp_retire);
    check("wrap_state", 32'(State), 32'(StIf));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
